// File: rtl/alu_ctrl.sv
// alu_ctrl: command FIFO that drives an external ALU and registers its result, with an accumulator operand option.
module alu_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  input  logic [1:0]               in_op,
  input  logic                     in_acc,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [1:0]               alu_op,
  input  logic [3:0]               alu_y,
  input  logic                     alu_carry,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_y,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic [3:0]               acc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [10:0]   head;
  logic          has, push, issue;
  assign head     = mem[rp];
  assign has      = count != '0;
  assign in_ready = count < FULL;
  assign push     = in_valid && in_ready;
  assign issue    = has && (!out_valid || out_ready);
  // acc feeds alu_a directly, so a dependent command issues the cycle after its producer
  always_comb begin
    alu_a  = !has ? 4'd0 : head[0] ? acc : head[10:7];
    alu_b  = has ? head[6:3] : 4'd0;
    alu_op = has ? head[2:1] : 2'd0;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {in_a, in_b, in_op, in_acc};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (issue) rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(issue);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y     <= 4'd0;
      out_carry <= 1'b0;
      out_zero  <= 1'b1;
      acc       <= 4'd0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_y     <= alu_y;
      out_carry <= alu_carry;
      out_zero  <= alu_y == 4'd0;
      acc       <= alu_y;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: random and directed stimulus checked every cycle against a queue-based model of alu_ctrl.
module tb_alu_ctrl;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_acc = 1'b0, out_ready = 1'b0;
  logic [3:0] in_a = '0, in_b = '0;
  logic [1:0] in_op = '0;
  logic in_ready, alu_carry, out_valid, out_carry, out_zero;
  logic [3:0] alu_a, alu_b, alu_y, out_y, acc;
  logic [1:0] alu_op;
  logic [CW-1:0] count;
  int checks = 0, errors = 0;
  typedef struct packed {logic [3:0] a; logic [3:0] b; logic [1:0] op; logic acc;} cmd_t;
  cmd_t q[$];
  logic m_ov, m_c, m_z;
  logic [3:0] m_y, m_acc;
  alu_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_carry(out_carry),
    .out_zero(out_zero), .acc(acc), .count(count)
  );
  always #5 clk = ~clk;
  function automatic logic [4:0] alu_fn(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'd0: return {1'b0, a} + {1'b0, b};
      2'd1: return {1'b0, a} - {1'b0, b};
      2'd2: return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction
  assign {alu_carry, alu_y} = alu_fn(alu_op, alu_a, alu_b);
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ov = 1'b0; m_y = '0; m_c = 1'b0; m_z = 1'b1; m_acc = '0;
    end else begin
      automatic bit do_push = in_valid && (q.size() < DEPTH);
      automatic bit do_issue = (q.size() > 0) && (!m_ov || out_ready);
      if (do_issue) begin
        automatic cmd_t h = q.pop_front();
        automatic logic [4:0] r = alu_fn(h.op, h.acc ? m_acc : h.a, h.b);
        m_ov = 1'b1; m_y = r[3:0]; m_c = r[4]; m_z = r[3:0] == 4'd0; m_acc = r[3:0];
      end else if (m_ov && out_ready) m_ov = 1'b0;
      if (do_push) q.push_back('{in_a, in_b, in_op, in_acc});
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      automatic bit h = q.size() > 0;
      chk("count", int'(count), q.size());
      chk("in_ready", int'(in_ready), int'(q.size() < DEPTH));
      chk("out_valid", int'(out_valid), int'(m_ov));
      chk("out_y", int'(out_y), int'(m_y));
      chk("out_carry", int'(out_carry), int'(m_c));
      chk("out_zero", int'(out_zero), int'(m_z));
      chk("acc", int'(acc), int'(m_acc));
      chk("alu_a", int'(alu_a), h ? int'(q[0].acc ? m_acc : q[0].a) : 0);
      chk("alu_b", int'(alu_b), h ? int'(q[0].b) : 0);
      chk("alu_op", int'(alu_op), h ? int'(q[0].op) : 0);
    end
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, input logic ac);
    in_valid = v; in_a = a; in_b = b; in_op = op; in_acc = ac;
  endtask
  initial begin
    logic [3:0] held;
    bit hit;
    step(); step();
    chk("rst_count", int'(count), 0);
    chk("rst_out_zero", int'(out_zero), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    chk("rel_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    drive(1, 4'd7, 4'd9, 2'd0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    chk("add79_valid", int'(out_valid), 1);
    chk("add79_y", int'(out_y), 0);
    chk("add79_carry", int'(out_carry), 1);
    chk("add79_zero", int'(out_zero), 1);
    chk("add79_acc", int'(acc), 0);
    drive(1, 4'd3, 4'd4, 2'd0, 0);
    step();
    drive(1, 4'd0, 4'd2, 2'd1, 1);
    step();
    chk("seq_y0", int'(out_y), 7);
    drive(1, 4'd0, 4'd8, 2'd3, 1);
    step();
    chk("seq_y1", int'(out_y), 5);
    drive(0, 0, 0, 0, 0);
    step();
    chk("seq_y2", int'(out_y), 13);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(1, 4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
      step();
    end
    drive(0, 0, 0, 0, 0);
    chk("full_count", int'(count), DEPTH);
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_out_valid", int'(out_valid), 1);
    held = out_y;
    step(); step();
    chk("held_out_y", int'(out_y), int'(held));
    out_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH; i++) step();
    chk("drain_count", int'(count), 0);
    chk("drain_valid", int'(out_valid), 0);
    out_ready = 1'b0;
    hit = 0;
    for (int i = 0; i < 4 * DEPTH && !hit; i++) begin
      drive(1, 4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
      step();
      hit = q.size() == DEPTH - 1;
    end
    chk("reach_depth_m1", int'(hit), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      drive(1, 4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
      step();
      chk("steady_count", int'(count), DEPTH - 1);
    end
    drive(0, 0, 0, 0, 0);
    out_ready = 1'b0;
    step();
    chk("pre_rst_count", int'(count), 3);
    chk("pre_rst_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_valid", int'(out_valid), 0);
    chk("async_acc", int'(acc), 0);
    chk("async_zero", int'(out_zero), 1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("no_stale_valid", int'(out_valid), 0);
    end
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO depth; SHALL be a power of two, at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  command offered.
REQ-005 in_ready  output  1  command FIFO can accept.
REQ-006 in_a, in_b  input  4 each  command operands.
REQ-007 in_op  input  2  operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-008 in_acc  input  1  when 1, operand A SHALL be the accumulator instead of in_a.
REQ-009 alu_a, alu_b  output  4 each  operands driven to the downstream ALU.
REQ-010 alu_op  output  2  operation driven to the ALU.
REQ-011 alu_y  input  4  ALU result; alu_carry  input  1  ALU carry/borrow.
REQ-012 out_valid  output  1  result register holds an unconsumed result.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_y  output  4  result; out_carry  output  1  carry; out_zero  output  1  result==0.
REQ-015 acc  output  4  accumulator, last captured result.
REQ-016 count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 Push SHALL occur when in_valid && in_ready; {in_a, in_b, in_op, in_acc} SHALL be written at the write pointer.
REQ-018 in_ready SHALL be 1 iff count < DEPTH; it SHALL depend only on count, so a full FIFO refuses a push even while popping.
REQ-019 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-020 While count > 0, alu_op and alu_b SHALL combinationally reflect the head entry; alu_a SHALL equal acc if head in_acc=1, else head in_a.
REQ-021 While count == 0, alu_a, alu_b and alu_op SHALL be 0.
REQ-022 Issue SHALL occur when count > 0 && (!out_valid || out_ready).
REQ-023 On issue, the following SHALL be captured and the head SHALL be popped, at the same edge:
- out_y <= alu_y
- out_carry <= alu_carry
- out_zero <= (alu_y == 0)
- acc <= alu_y
- out_valid <= 1
REQ-024 If out_valid && out_ready and no issue, out_valid SHALL clear; out_y, out_carry, out_zero and acc SHALL hold.
REQ-025 If out_valid && !out_ready, out_y, out_carry and out_zero SHALL hold, and no issue SHALL occur.
REQ-026 Simultaneous push and issue SHALL leave count unchanged.
REQ-027 Throughput SHALL be one command per cycle with out_ready held 1.
REQ-028 Latency: a push at edge N SHALL be issued no earlier than edge N+1, with the result visible after edge N+1 when the FIFO was empty and the output free.
REQ-029 Back-to-back in_acc commands SHALL use the acc value captured at the previous issue; the dependency SHALL cost no extra cycle.
REQ-030 The block SHALL perform no arithmetic; all results SHALL come from alu_y and alu_carry.

Reset
REQ-031 rst_n low SHALL immediately clear all of the following, independent of clk:
- count, read pointer and write pointer
- out_valid, out_y, out_carry and acc
- out_zero, which SHALL be set to 1
REQ-032 Reset asserted mid-operation SHALL discard all queued and unconsumed commands; no result SHALL appear after release.
REQ-033 FIFO storage contents SHALL not require reset.
REQ-034 in_ready SHALL be 1 from the first cycle after reset release.

Verification (bench models the ALU as ADD/SUB/AND/OR on 4 bits, carry = bit 4)
REQ-035 Push ADD a=7 b=9 in_acc=0 with out_ready=1 -> one cycle later out_valid=1, out_y=0, out_carry=1, out_zero=1, acc=0.
REQ-036 Push ADD 3+4, then SUB in_acc=1 b=2, then OR in_acc=1 b=8, back-to-back with out_ready=1 -> out_y sequence 7, 5, 13 on consecutive cycles.
REQ-037 Hold out_ready=0 and push DEPTH+2 commands -> one result held in the output register, then count=DEPTH, in_ready=0, and out_y stable.
REQ-038 Release out_ready -> results emerge in push order with none lost or duplicated.
REQ-039 Keep count at DEPTH-1 with simultaneous push and issue for 3*DEPTH cycles -> count constant and pointers wrap cleanly.
REQ-040 Assert rst_n=0 mid-cycle with count=3 and out_valid=1 -> immediately count=0, out_valid=0, acc=0, out_zero=1.
REQ-041 After REQ-040, release rst_n -> no stale result appears.
